// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, shadow-slot layout,
// and the register-match helper used by the scoreboard comparators.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
  } slot_t;

  localparam logic [4:0] X0     = 5'd0;
  localparam slot_t      BUBBLE = '{valid: 1'b0, rd: X0, wr: 1'b0};

  // True when an in-flight slot will write register r (x0 never counts).
  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid && s.wr && (s.rd == r) && (r != X0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow of the EX/MEM/WB destination registers and the RAW
// comparators against the instruction currently held in ID.
module hazard_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       branch_taken,
  output logic       stall
);

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  logic  hazard;
  logic  issue;

  always_comb begin
    hazard = 1'b0;
    if (id_use_rs1 && (slot_hit(ex_slot, id_rs1) || slot_hit(mem_slot, id_rs1) ||
                       (!WB_BYPASS && slot_hit(wb_slot, id_rs1))))
      hazard = 1'b1;
    if (id_use_rs2 && (slot_hit(ex_slot, id_rs2) || slot_hit(mem_slot, id_rs2) ||
                       (!WB_BYPASS && slot_hit(wb_slot, id_rs2))))
      hazard = 1'b1;
  end

  assign stall = id_valid && run && hazard;
  assign issue = id_valid && !stall && !branch_taken && run;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot  <= BUBBLE;
      mem_slot <= BUBBLE;
      wb_slot  <= BUBBLE;
    end else if (branch_taken) begin
      // The branch itself sits in MEM and survives into WB; younger work is squashed.
      ex_slot  <= BUBBLE;
      mem_slot <= BUBBLE;
      wb_slot  <= mem_slot;
    end else begin
      ex_slot  <= issue ? '{valid: 1'b1, rd: id_rd, wr: id_reg_write} : BUBBLE;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the 5-stage no-forwarding pipeline: stall/flush
// generation, end-of-program drain/halt FSM and saturating event counters.
module pipeline_hazard_controller
  import cpu_pipe_pkg::*;
#(
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_nop,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             branch_taken,
  input  logic             wb_valid,
  input  logic             wb_nop,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_t state_q;
  logic   run;
  logic   stall;
  logic   flush_evt;

  assign run       = (state_q == RUN);
  assign flush_evt = branch_taken && (state_q != HALT);
  assign state     = state_q;

  hazard_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .branch_taken (branch_taken),
    .stall        (stall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (id_valid && id_nop && !stall && !branch_taken)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (branch_taken)
            state_q <= RUN;
          else if (wb_valid && wb_nop)
            state_q <= HALT;
        end
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
      if (flush_evt && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
      if (stall && !branch_taken && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  // Enables depend on the same-cycle hazard, so they decode combinationally
  // from the registered state rather than being registered themselves.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    if (reset || state_q == HALT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      halted       = !reset;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state_q == DRAIN || stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: one instance with WB bypass and 32-bit counters, one without
// bypass and 2-bit counters, driven with the same ID/MEM/WB stimulus.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_nop, id_use_rs1, id_use_rs2, id_reg_write;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       branch_taken, wb_valid, wb_nop;

  logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, halted_a;
  logic [1:0]  state_a;
  logic [31:0] stall_count_a, flush_count_a;
  logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, halted_b;
  logic [1:0]  state_b;
  logic [1:0]  stall_count_b, flush_count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.WB_BYPASS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_nop(id_nop),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .branch_taken(branch_taken),
    .wb_valid(wb_valid), .wb_nop(wb_nop), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
    .halted(halted_a), .state(state_a), .stall_count(stall_count_a), .flush_count(flush_count_a)
  );

  pipeline_hazard_controller #(.WB_BYPASS(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_nop(id_nop),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .branch_taken(branch_taken),
    .wb_valid(wb_valid), .wb_nop(wb_nop), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
    .halted(halted_b), .state(state_b), .stall_count(stall_count_b), .flush_count(flush_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic nop, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr);
    id_valid = v; id_nop = nop; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd; id_reg_write = wr;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; branch_taken = 1'b0; wb_valid = 1'b0; wb_nop = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; branch_taken = 1'b0; wb_valid = 1'b0; wb_nop = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pc_en_a !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%0b exp=0", pc_en_a); end
    checks++; if (if_id_en_a !== 1'b0) begin failures++; $display("FAIL rst_if_id_en got=%0b exp=0", if_id_en_a); end
    checks++; if ({if_id_flush_a, id_ex_flush_a, ex_mem_flush_a} !== 3'b111) begin failures++; $display("FAIL rst_flushes got=%b exp=111", {if_id_flush_a, id_ex_flush_a, ex_mem_flush_a}); end
    checks++; if (halted_a !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted_a); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (state_a !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_a); end
    checks++; if (stall_count_a !== 32'd0 || flush_count_a !== 32'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", stall_count_a, flush_count_a); end
    checks++; if (pc_en_a !== 1'b1 || if_id_en_a !== 1'b1) begin failures++; $display("FAIL rst_run_en got=%0b%0b exp=11", pc_en_a, if_id_en_a); end
  endtask

  // addi x1,x0,5 ; add x2,x1,x1 : 2 stalls with bypass, 3 without.
  task automatic test_raw_stall();
    apply_reset();
    set_id(1, 0, 0, 1, 0, 0, 1, 1);
    checks++; if (pc_en_a !== 1'b1 || pc_en_b !== 1'b1) begin failures++; $display("FAIL raw_c1_pc_en got=%0b%0b exp=11", pc_en_a, pc_en_b); end
    tick();
    set_id(1, 0, 1, 1, 1, 1, 2, 1);
    checks++; if (pc_en_a !== 1'b0 || pc_en_b !== 1'b0) begin failures++; $display("FAIL raw_c2_pc_en got=%0b%0b exp=00", pc_en_a, pc_en_b); end
    checks++; if (if_id_en_a !== 1'b0 || id_ex_flush_a !== 1'b1 || ex_mem_flush_a !== 1'b0) begin failures++; $display("FAIL raw_c2_ctl got=%0b%0b%0b exp=010", if_id_en_a, id_ex_flush_a, ex_mem_flush_a); end
    tick();
    checks++; if (pc_en_a !== 1'b0 || pc_en_b !== 1'b0) begin failures++; $display("FAIL raw_c3_pc_en got=%0b%0b exp=00", pc_en_a, pc_en_b); end
    checks++; if (stall_count_a !== 32'd1) begin failures++; $display("FAIL raw_c3_cnt got=%0d exp=1", stall_count_a); end
    tick();
    checks++; if (pc_en_a !== 1'b1 || pc_en_b !== 1'b0) begin failures++; $display("FAIL raw_c4_pc_en got=%0b%0b exp=10", pc_en_a, pc_en_b); end
    checks++; if (stall_count_a !== 32'd2 || stall_count_b !== 2'd2) begin failures++; $display("FAIL raw_c4_cnt got=%0d/%0d exp=2/2", stall_count_a, stall_count_b); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall_count_a !== 32'd2) begin failures++; $display("FAIL raw_bypass_total got=%0d exp=2", stall_count_a); end
    checks++; if (stall_count_b !== 2'd3) begin failures++; $display("FAIL raw_nobypass_total got=%0d exp=3", stall_count_b); end
    checks++; if (pc_en_b !== 1'b1) begin failures++; $display("FAIL raw_c5_pc_en_b got=%0b exp=1", pc_en_b); end
  endtask

  // Two rounds of a load-use style dependency: 2-bit counter must stick at 3.
  task automatic test_saturation();
    apply_reset();
    for (int unsigned r = 0; r < 2; r++) begin
      set_id(1, 0, 0, 1, 0, 0, 5, 1);
      tick();
      set_id(1, 0, 5, 1, 0, 0, 0, 0);
      tick(); tick(); tick();
      if (r == 0) begin
        checks++; if (stall_count_b !== 2'd3) begin failures++; $display("FAIL sat_round1_b got=%0d exp=3", stall_count_b); end
      end
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall_count_a !== 32'd4) begin failures++; $display("FAIL sat_count_a got=%0d exp=4", stall_count_a); end
    checks++; if (stall_count_b !== 2'd3) begin failures++; $display("FAIL sat_count_b got=%0d exp=3", stall_count_b); end
  endtask

  // beq reaches MEM taken while a dependent add stalls in ID.
  task automatic test_branch();
    apply_reset();
    set_id(1, 0, 0, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 1, 0, 0, 6, 1);
    tick();
    branch_taken = 1'b1;
    set_id(1, 0, 6, 1, 6, 1, 7, 1);
    checks++; if ({if_id_flush_a, id_ex_flush_a, ex_mem_flush_a} !== 3'b111) begin failures++; $display("FAIL br_flushes got=%b exp=111", {if_id_flush_a, id_ex_flush_a, ex_mem_flush_a}); end
    checks++; if (pc_en_a !== 1'b1 || pc_en_b !== 1'b1) begin failures++; $display("FAIL br_pc_en got=%0b%0b exp=11", pc_en_a, pc_en_b); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (flush_count_a !== 32'd1 || flush_count_b !== 2'd1) begin failures++; $display("FAIL br_flush_count got=%0d/%0d exp=1/1", flush_count_a, flush_count_b); end
    checks++; if (stall_count_a !== 32'd0 || stall_count_b !== 2'd0) begin failures++; $display("FAIL br_no_stall_count got=%0d/%0d exp=0/0", stall_count_a, stall_count_b); end
    checks++; if (pc_en_a !== 1'b1 || pc_en_b !== 1'b1 || id_ex_flush_a !== 1'b0) begin failures++; $display("FAIL br_squashed_x6 got=%0b%0b%0b exp=110", pc_en_a, pc_en_b, id_ex_flush_a); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset lands while a dependent add stalls on x1 held in the EX slot.
  task automatic test_reset_mid();
    set_id(1, 0, 0, 1, 0, 0, 9, 1);
    tick();
    set_id(1, 0, 9, 1, 0, 0, 0, 0);
    checks++; if (pc_en_a !== 1'b0) begin failures++; $display("FAIL rm_stall got=%0b exp=0", pc_en_a); end
    tick();
    set_id(1, 0, 0, 1, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 1, 1, 1, 3, 1);
    checks++; if (stall_count_a !== 32'd1 || flush_count_a !== 32'd1) begin failures++; $display("FAIL rm_pre_counts got=%0d/%0d exp=1/1", stall_count_a, flush_count_a); end
    reset = 1'b1;
    #1;
    checks++; if (pc_en_a !== 1'b0 || if_id_en_a !== 1'b0 || ex_mem_flush_a !== 1'b1 || halted_a !== 1'b0) begin failures++; $display("FAIL rm_in_reset got=%0b%0b%0b%0b exp=0010", pc_en_a, if_id_en_a, ex_mem_flush_a, halted_a); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (pc_en_a !== 1'b1 || if_id_en_a !== 1'b1 || id_ex_flush_a !== 1'b0 || pc_en_b !== 1'b1) begin failures++; $display("FAIL rm_add_issues got=%0b%0b%0b%0b exp=1101", pc_en_a, if_id_en_a, id_ex_flush_a, pc_en_b); end
    checks++; if (stall_count_a !== 32'd0 || flush_count_a !== 32'd0 || state_a !== 2'd0) begin failures++; $display("FAIL rm_cleared got=%0d/%0d/%0d exp=0/0/0", stall_count_a, flush_count_a, state_a); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall_count_a !== 32'd0 || stall_count_b !== 2'd0) begin failures++; $display("FAIL rm_no_stall got=%0d/%0d exp=0/0", stall_count_a, stall_count_b); end
  endtask

  task automatic test_x0();
    apply_reset();
    set_id(1, 0, 0, 1, 0, 0, 0, 1);
    tick();
    set_id(1, 0, 0, 1, 0, 1, 4, 1);
    checks++; if (pc_en_a !== 1'b1 || pc_en_b !== 1'b1) begin failures++; $display("FAIL x0_c2 got=%0b%0b exp=11", pc_en_a, pc_en_b); end
    tick();
    set_id(1, 0, 0, 1, 0, 1, 0, 0);
    checks++; if (pc_en_b !== 1'b1) begin failures++; $display("FAIL x0_c3_b got=%0b exp=1", pc_en_b); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall_count_a !== 32'd0 || stall_count_b !== 2'd0) begin failures++; $display("FAIL x0_counts got=%0d/%0d exp=0/0", stall_count_a, stall_count_b); end
  endtask

  task automatic test_drain_branch();
    apply_reset();
    set_id(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (state_a !== 2'd1 || pc_en_a !== 1'b0 || id_ex_flush_a !== 1'b1 || if_id_flush_a !== 1'b0) begin failures++; $display("FAIL db_drain got=%0d%0b%0b%0b exp=1010", state_a, pc_en_a, id_ex_flush_a, if_id_flush_a); end
    branch_taken = 1'b1;
    #1;
    checks++; if (pc_en_a !== 1'b1 || ex_mem_flush_a !== 1'b1 || if_id_flush_a !== 1'b1) begin failures++; $display("FAIL db_branch got=%0b%0b%0b exp=111", pc_en_a, ex_mem_flush_a, if_id_flush_a); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (state_a !== 2'd0 || flush_count_a !== 32'd1 || pc_en_a !== 1'b1) begin failures++; $display("FAIL db_back_to_run got=%0d/%0d/%0b exp=0/1/1", state_a, flush_count_a, pc_en_a); end
  endtask

  task automatic test_drain_halt();
    apply_reset();
    set_id(1, 0, 0, 1, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 0, 1, 0, 0, 2, 1);
    tick();
    set_id(1, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (state_a !== 2'd0 || pc_en_a !== 1'b1 || pc_en_b !== 1'b1) begin failures++; $display("FAIL dh_marker got=%0d%0b%0b exp=011", state_a, pc_en_a, pc_en_b); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (state_a !== 2'd1 || pc_en_a !== 1'b0 || if_id_en_a !== 1'b0 || halted_a !== 1'b0) begin failures++; $display("FAIL dh_drain got=%0d%0b%0b%0b exp=1000", state_a, pc_en_a, if_id_en_a, halted_a); end
    wb_valid = 1'b1; wb_nop = 1'b0;
    tick();
    checks++; if (state_a !== 2'd1) begin failures++; $display("FAIL dh_wb_real got=%0d exp=1", state_a); end
    wb_nop = 1'b1;
    #1;
    checks++; if (state_a !== 2'd1 || halted_a !== 1'b0) begin failures++; $display("FAIL dh_wb_nop_same got=%0d%0b exp=10", state_a, halted_a); end
    tick();
    wb_valid = 1'b0; wb_nop = 1'b0; branch_taken = 1'b1;
    #1;
    checks++; if (state_a !== 2'd2 || halted_a !== 1'b1 || state_b !== 2'd2) begin failures++; $display("FAIL dh_halt got=%0d%0b%0d exp=212", state_a, halted_a, state_b); end
    checks++; if ({pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a} !== 5'b00111) begin failures++; $display("FAIL dh_halt_ctl got=%b exp=00111", {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a}); end
    tick();
    branch_taken = 1'b0;
    set_id(1, 0, 0, 1, 0, 0, 3, 1);
    tick();
    checks++; if (halted_a !== 1'b1 || state_a !== 2'd2 || pc_en_a !== 1'b0) begin failures++; $display("FAIL dh_sticky got=%0b%0d%0b exp=120", halted_a, state_a, pc_en_a); end
    checks++; if (flush_count_a !== 32'd0 || stall_count_a !== 32'd0) begin failures++; $display("FAIL dh_frozen got=%0d/%0d exp=0/0", flush_count_a, stall_count_a); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw_stall();
    test_saturation();
    test_branch();
    test_reset_mid();
    test_x0();
    test_drain_branch();
    test_drain_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
